// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - W-bit add/subtract sequenced one nibble per cycle through a shared 4-bit adder
module adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [4:0] total;

  assign total = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
  assign S     = total[3:0];
  assign Cout  = total[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = $clog2(NIBBLES)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    nib_a, nib_b, add_s;
  logic          add_cout;

  assign nib_a = opa_q[{idx_q, 2'b00} +: 4];
  assign nib_b = opb_q[{idx_q, 2'b00} +: 4];

  adder u_adder (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .S    (add_s),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction becomes A + ~B + 1 by seeding the carry with sub.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d[{idx_q, 2'b00} +: 4] = add_s;
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NIBBLES - 1)) begin
          sum_d   = acc_d;
          cout_d  = add_cout;
          ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (add_s[3] != opa_q[W-1]);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule
